neosd_cmd_engine: RTL and testbench
===================================

# neosd_cmd_engine

Parametrised SD-card CMD-line engine for the neosd controller: generates the SD clock from the system clock with a runtime divider, serialises a 48-bit command frame with hardware-generated CRC7, and receives a 48-bit or 136-bit response with start-bit timeout and optional CRC7/end-bit checking. It sits between the neosd register file, which drives start/idx/arg/rmode and reads resp/status, and the SD pad drivers.

## Interface
- `CLKDIV_W`, default 8: width of the SD clock divider input.
- `TIMEOUT`, default 64: maximum number of SD clock rising edges to wait for a response start bit (NCR).

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: system clock. This is the only clock.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `div_i`, in, CLKDIV_W: SD clock half-period minus 1, in clk_i cycles. Latched when start is accepted.
- `start_i`, in, 1: command request. Accepted only in IDLE.
- `abort_i`, in, 1: cancels any transfer in progress.
- `idx_i`, in, 6: command index.
- `arg_i`, in, 32: command argument.
- `rmode_i`, in, 2: response mode. 0 = none, 1 = short (48 bit), 2 = long (136 bit), 3 = treated as short.
- `busy_o`, out, 1: high whenever the engine is not in IDLE.
- `done_o`, out, 1: one-cycle pulse when a command completes.
- `timeout_o`, out, 1: sticky flag; no response start bit was seen within TIMEOUT edges.
- `crc_err_o`, out, 1: sticky flag; the response CRC7 or end bit was bad.
- `resp_o`, out, 136: raw response frame, right-aligned. A short response occupies [47:0] and the upper bits read 0.
- `sd_clk_o`, out, 1: SD clock.
- `sd_cmd_o`, out, 1: CMD line output data.
- `sd_cmd_oe`, out, 1: CMD line output enable.
- `sd_cmd_i`, in, 1: CMD line input.

## Operation
- **States:** IDLE, TX, WAIT, RX.
- **IDLE → TX:** taken on `start_i`. On acceptance the engine latches `div_i`, `idx_i`, `arg_i` and `rmode_i`, and clears `timeout_o`, `crc_err_o` and `resp_o`.
- **TX frame:** 48 bits, MSB first: `{1'b0, 1'b1, idx, arg, crc7, 1'b1}`.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over frame bits [47:8].
- **TX → IDLE:** taken after the final bit period when rmode = none. `done_o` pulses.
- **TX → WAIT:** taken after the final bit period otherwise.
  - `sd_cmd_oe` drops to 0 and `sd_cmd_o` returns to 1.
- **WAIT:** samples `sd_cmd_i` on each SD rising edge.
  - A sampled 0 is the response start bit: shift it in and go to RX.
  - If TIMEOUT rising edges pass with no 0 sampled: set `timeout_o`, pulse `done_o`, go to IDLE.
- **RX:** shifts `sd_cmd_i` into `resp_o` LSB-first-in on each rising edge until 48 or 136 bits in total (start bit included) have been received. Then pulse `done_o` and go to IDLE.
- **Abort:** `abort_i` in any non-IDLE state returns the engine to IDLE on the next cycle.
  - `sd_cmd_oe` = 0, `sd_clk_o` = 0.
  - No `done_o` pulse; flags and `resp_o` keep their current values.
  - If `abort_i` and `start_i` are asserted together in IDLE, abort wins and the start is dropped.
- **Start while busy:** `start_i` is ignored.

## Timing
- **Reset values:** `sd_clk_o` = 0, `sd_cmd_o` = 1, `sd_cmd_oe` = 0, `busy_o` = 0, `done_o` = 0, `timeout_o` = 0, `crc_err_o` = 0, `resp_o` = 0, state = IDLE.
- **Reset mid-operation:** all outputs go to their reset values immediately (asynchronous).
- **SD clock:** a divider counter runs from 0 to the latched div; at div, `sd_clk_o` toggles and the counter wraps to 0.
  - SD period is 2·(div+1) clk_i cycles.
  - `sd_clk_o` toggles only in TX, WAIT and RX; it is held at 0 in IDLE.
- **Start latency:** in the cycle after acceptance, `busy_o` = 1, `sd_cmd_oe` = 1, and `sd_cmd_o` = frame bit 47 (0), with `sd_clk_o` low.
- **Output change:** `sd_cmd_o` advances on the clk_i cycle where `sd_clk_o` goes 1 → 0.
- **Input sampling:** `sd_cmd_i` is sampled on the cycle where `sd_clk_o` goes 0 → 1.
- **Command duration (no response):** `done_o` fires exactly 48·2·(div+1) cycles after the first TX cycle. `busy_o` falls in the same cycle as `done_o`.
- **Flag timing:** `timeout_o` and `crc_err_o` become valid in the same cycle as `done_o` and hold until the next accepted start.
- **Divider edge case:** div = 0 is legal and gives an SD clock of clk_i/2.

## Configuration
- **Macro:** `NEOSD_CMD_CRC_CHECK_EN`.
- **Defined:** a receive CRC7 is computed over frame bits [47:8] (short) or [127:8] (long) and compared with bits [7:1]. On mismatch, or if bit 0 ≠ 1, `crc_err_o` is set at `done_o`.
- **Undefined:** no receive CRC logic is built and `crc_err_o` is tied to 0. Transmit CRC7 generation is always present.

## Test plan
- **CMD0:** idx=0, arg=0, rmode=0, div=0 → `sd_cmd_o` serialises 48'h40_0000_0000_95; `done_o` pulses 96 cycles after the first TX cycle; `sd_cmd_oe` = 0 afterwards.
- **CMD8:** idx=8, arg=32'h1AA, rmode=1, div=3. The card model returns 48'h08_0000_01AA_13 after 5 SD clocks → TX frame 48'h48_0000_01AA_87; `resp_o` = 48'h08_0000_01AA_13; `crc_err_o` = 0.
- **Corrupted response:** same as CMD8 but the response ends 0x12 → with the macro, `crc_err_o` = 1; without it, `crc_err_o` = 0.
- **Timeout:** rmode=1 and `sd_cmd_i` held at 1 → `timeout_o` = 1 and `done_o` pulse after exactly TIMEOUT SD rising edges in WAIT.
- **Long response:** rmode=2 with a 136-bit CSD frame carrying a valid CRC → all 136 bits appear in `resp_o`; `crc_err_o` = 0.
- **Abort and reset:** `abort_i` mid-TX → IDLE next cycle, `sd_clk_o` = 0, no `done_o`. `start_i` + `abort_i` together in IDLE → `busy_o` stays 0. `rstn_i` pulsed low during RX → all outputs at reset values immediately.

Source files
------------

// File: rtl/neosd_cmd_if.sv
// Host-side bus of the neosd CMD-line engine: command request from the register
// file and response/status back to it.
interface neosd_cmd_if #(
  parameter int CLKDIV_W = 8
);
  logic [CLKDIV_W-1:0] div_i;
  logic                start_i;
  logic                abort_i;
  logic [5:0]          idx_i;
  logic [31:0]         arg_i;
  logic [1:0]          rmode_i;
  logic                busy_o;
  logic                done_o;
  logic                timeout_o;
  logic                crc_err_o;
  logic [135:0]        resp_o;

  modport master (
    output div_i, start_i, abort_i, idx_i, arg_i, rmode_i,
    input  busy_o, done_o, timeout_o, crc_err_o, resp_o
  );

  modport slave (
    input  div_i, start_i, abort_i, idx_i, arg_i, rmode_i,
    output busy_o, done_o, timeout_o, crc_err_o, resp_o
  );
endinterface

// File: rtl/neosd_cmd_engine.sv
// SD CMD-line engine: SD clock divider, 48-bit command TX with CRC7, 48/136-bit
// response RX with start-bit timeout. Receive CRC7/end-bit check: NEOSD_CMD_CRC_CHECK_EN.
module neosd_cmd_engine #(
  parameter int CLKDIV_W = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  neosd_cmd_if.slave bus,
  output logic       sd_clk_o,
  output logic       sd_cmd_o,
  output logic       sd_cmd_oe,
  input  logic       sd_cmd_i
);
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TX, S_WAIT, S_RX} state_t;

  typedef struct packed {
    logic [CLKDIV_W-1:0] div;
    logic                has_rsp;
    logic                long_rsp;
  } cfg_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [47:0] tx_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [6:0]  c;
    hdr = {2'b01, idx, arg};
    c   = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, hdr[i]);
    return {hdr, c, 1'b1};
  endfunction

  state_t         state_q, state_d;
  cfg_t           cfg_q;
  logic [CLKDIV_W-1:0] cnt_q;
  logic           sclk_q;
  logic [47:0]    tx_sr_q;
  logic [7:0]     bit_cnt_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [135:0]   resp_q;
  logic           done_q, tout_q;
  logic           accept, run, tick, rise, fall;
  logic           last_tx, last_rx, tout_hit, rx_bit;
  logic           finish, set_tout;

  // abort beats a simultaneous start and freezes everything but the FSM
  assign accept   = (state_q == S_IDLE) && bus.start_i && !bus.abort_i;
  assign run      = (state_q != S_IDLE) && !bus.abort_i;
  assign tick     = (state_q != S_IDLE) && (cnt_q == cfg_q.div);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;
  assign last_tx  = (bit_cnt_q == 8'd47);
  assign last_rx  = (bit_cnt_q == (cfg_q.long_rsp ? 8'd135 : 8'd47));
  assign tout_hit = (wait_cnt_q == WCW'(TIMEOUT - 1));
  assign rx_bit   = run && rise &&
                    (((state_q == S_WAIT) && !sd_cmd_i) || (state_q == S_RX));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    finish   = 1'b0;
    set_tout = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_TX;
      S_TX: begin
        if (fall && last_tx) begin
          if (cfg_q.has_rsp) state_d = S_WAIT;
          else begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rise) begin
          if (!sd_cmd_i) state_d = S_RX;
          else if (tout_hit) begin
            state_d  = S_IDLE;
            finish   = 1'b1;
            set_tout = 1'b1;
          end
        end
      end
      S_RX: begin
        if (rise && last_rx) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      finish   = 1'b0;
      set_tout = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_q      <= '0;
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      tx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      resp_q     <= '0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        cfg_q.div      <= bus.div_i;
        cfg_q.has_rsp  <= (bus.rmode_i != 2'd0);
        cfg_q.long_rsp <= (bus.rmode_i == 2'd2);
        tx_sr_q        <= tx_frame(bus.idx_i, bus.arg_i);
        bit_cnt_q      <= '0;
        wait_cnt_q     <= '0;
        resp_q         <= '0;
        tout_q         <= 1'b0;
      end
      if (run && fall && (state_q == S_TX)) begin
        tx_sr_q   <= {tx_sr_q[46:0], 1'b0};
        bit_cnt_q <= last_tx ? 8'd0 : bit_cnt_q + 8'd1;
      end
      if (run && rise && (state_q == S_WAIT) && sd_cmd_i) wait_cnt_q <= wait_cnt_q + 1'b1;
      // response shifts in from the right; start bit counts as bit 0
      if (rx_bit) begin
        resp_q    <= {resp_q[134:0], sd_cmd_i};
        bit_cnt_q <= bit_cnt_q + 8'd1;
      end
      if (set_tout) tout_q <= 1'b1;
      if (accept || (state_d == S_IDLE)) begin
        cnt_q  <= '0;
        sclk_q <= 1'b0;
      end else if (tick) begin
        cnt_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

`ifdef NEOSD_CMD_CRC_CHECK_EN
  logic [6:0] rx_crc_q;
  logic       crc_err_q;
  logic       in_crc;

  // CRC covers [47:8] of a short frame, [127:8] of a long one (by arrival index)
  assign in_crc = cfg_q.long_rsp ? ((bit_cnt_q >= 8'd8) && (bit_cnt_q < 8'd128))
                                 : (bit_cnt_q < 8'd40);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_crc_q  <= '0;
      crc_err_q <= 1'b0;
    end else begin
      if (accept) begin
        rx_crc_q  <= '0;
        crc_err_q <= 1'b0;
      end
      if (rx_bit && in_crc) rx_crc_q <= crc7_step(rx_crc_q, sd_cmd_i);
      // resp_q[6:0] becomes [7:1] with the end bit arriving now
      if (finish && (state_q == S_RX))
        crc_err_q <= (rx_crc_q != resp_q[6:0]) || !sd_cmd_i;
    end
  end

  assign bus.crc_err_o = crc_err_q;
`else
  assign bus.crc_err_o = 1'b0;
`endif

  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.done_o    = done_q;
  assign bus.timeout_o = tout_q;
  assign bus.resp_o    = resp_q;
  assign sd_clk_o      = sclk_q;
  assign sd_cmd_oe     = (state_q == S_TX);
  assign sd_cmd_o      = sd_cmd_oe ? tx_sr_q[47] : 1'b1;
endmodule

// File: tb/tb_neosd_cmd_engine.sv
// Randomized bench for neosd_cmd_engine: reference frames/CRCs from polynomial
// division, a cycle-count timing model and a bit-serial card model.
module tb_neosd_cmd_engine;
  localparam int DW = 8;
  localparam int TO = 64;

`ifdef NEOSD_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sd_clk, sd_cmd_o, sd_cmd_oe;
  logic sd_cmd_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  neosd_cmd_if #(.CLKDIV_W(DW)) bus ();

  neosd_cmd_engine #(.CLKDIV_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus),
    .sd_clk_o(sd_clk), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // remainder of m(x)*x^7 mod x^7+x^3+1; leading zeros do not change it
  function automatic logic [6:0] ref_crc7(input logic [119:0] m);
    logic [126:0] r;
    r = {m, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_tx(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({80'd0, 2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [135:0] mk_resp(input bit is_long, input logic [119:0] body,
                                           input bit corrupt, input int flip);
    logic [135:0] f;
    if (is_long) f = {8'h3F, body, ref_crc7(body), 1'b1};
    else         f = {88'd0, 2'b00, body[37:0], ref_crc7({80'd0, 2'b00, body[37:0]}), 1'b1};
    if (corrupt) f[flip] = ~f[flip];
    return f;
  endfunction

  // lat < 0: card never answers; else lat idle SD clocks precede the start bit
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rmode, input int div, input int lat,
                         input logic [135:0] rframe, input logic [47:0] exp_tx,
                         input bit exp_crc);
    int r_len, n, f, ntx, done_n, n_exp, j;
    logic prev;
    logic [47:0] got;
    logic [135:0] exp_resp;
    bit exp_to, exp_ce;
    r_len = (rmode == 2'd0) ? 0 : (rmode == 2'd2) ? 136 : 48;
    if (r_len == 0) begin
      n_exp = 96 * (div + 1); exp_resp = '0; exp_to = 1'b0; exp_ce = 1'b0;
    end else if (lat < 0) begin
      n_exp = (div + 1) * (95 + 2 * TO); exp_resp = '0; exp_to = 1'b1; exp_ce = 1'b0;
    end else begin
      n_exp = (div + 1) * (95 + 2 * (lat + r_len)); exp_resp = rframe;
      exp_to = 1'b0; exp_ce = exp_crc;
    end
    @(negedge clk);
    bus.div_i = DW'(div); bus.idx_i = idx; bus.arg_i = arg; bus.rmode_i = rmode;
    bus.start_i = 1'b1; sd_cmd_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk({tag, "/start"}, {bus.busy_o, sd_cmd_oe, sd_cmd_o, sd_clk}, 4'b1100);
    n = 0; f = 0; ntx = 0; done_n = -1; got = '0; prev = sd_clk;
    while (done_n < 0 && n < n_exp + 64) begin
      @(negedge clk);
      n++;
      if (!prev && sd_clk && sd_cmd_oe) begin
        got = {got[46:0], sd_cmd_o};
        ntx++;
      end
      if (prev && !sd_clk && bus.busy_o && !sd_cmd_oe) begin
        f++;
        j = f - lat - 1;
        if (lat >= 0 && j >= 0 && j < r_len) sd_cmd_i = rframe[r_len - 1 - j];
        else sd_cmd_i = 1'b1;
      end
      if (bus.done_o) done_n = n;
      prev = sd_clk;
    end
    sd_cmd_i = 1'b1;
    chk({tag, "/done_at"}, done_n, n_exp);
    chk({tag, "/tx_frame"}, got, exp_tx);
    chk({tag, "/tx_bits"}, ntx, 48);
    chk({tag, "/resp"}, bus.resp_o, exp_resp);
    chk({tag, "/timeout"}, bus.timeout_o, exp_to);
    chk({tag, "/crc_err"}, bus.crc_err_o, exp_ce);
    chk({tag, "/idle"}, {bus.busy_o, sd_cmd_oe, sd_cmd_o}, 3'b001);
    @(negedge clk);
    chk({tag, "/pulse"}, {bus.done_o, bus.busy_o, sd_clk}, 3'b000);
  endtask

  logic [5:0]   r_idx;
  logic [31:0]  r_arg;
  logic [1:0]   r_rm;
  logic [119:0] r_body;
  logic [135:0] r_frame;
  int           r_div, r_lat, r_k, r_done;
  bit           r_bad;

  initial begin
    bus.div_i = '0; bus.start_i = 1'b0; bus.abort_i = 1'b0;
    bus.idx_i = '0; bus.arg_i = '0; bus.rmode_i = '0;
    #2;
    chk("reset/ctl", {sd_clk, sd_cmd_o, sd_cmd_oe, bus.busy_o, bus.done_o,
                      bus.timeout_o, bus.crc_err_o}, 7'b0100000);
    chk("reset/resp", bus.resp_o, 136'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_cmd("cmd0", 6'd0, 32'd0, 2'd0, 0, 0, '0, 48'h40_0000_0000_95, 1'b0);
    run_cmd("cmd8", 6'd8, 32'h1AA, 2'd1, 3, 5, 136'h08_0000_01AA_13,
            48'h48_0000_01AA_87, 1'b0);
    run_cmd("cmd8_bad", 6'd8, 32'h1AA, 2'd1, 3, 5, 136'h08_0000_01AA_12,
            48'h48_0000_01AA_87, CRC_EN);
    r_arg = $urandom;
    run_cmd("timeout", 6'd55, r_arg, 2'd1, 0, -1, '0, mk_tx(6'd55, r_arg), 1'b0);
    r_body = {$urandom, $urandom, $urandom, $urandom};
    r_frame = mk_resp(1'b1, r_body, 1'b0, 0);
    run_cmd("csd", 6'd9, 32'hABCD_0000, 2'd2, 1, 3, r_frame, mk_tx(6'd9, 32'hABCD_0000), 1'b0);

    for (int t = 0; t < 10; t++) begin
      r_idx = 6'($urandom); r_arg = $urandom; r_rm = 2'($urandom);
      r_div = $urandom_range(0, 3);
      r_lat = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 10);
      r_bad = ($urandom_range(0, 3) == 0);
      r_body = {$urandom, $urandom, $urandom, $urandom};
      r_frame = mk_resp(r_rm == 2'd2, r_body, r_bad, $urandom_range(0, 7));
      run_cmd($sformatf("rnd%0d", t), r_idx, r_arg, r_rm, r_div, r_lat, r_frame,
              mk_tx(r_idx, r_arg), r_bad && CRC_EN);
    end

    // abort mid-TX
    r_div = $urandom_range(0, 3);
    r_k = $urandom_range(2, 90 * (r_div + 1));
    @(negedge clk);
    bus.div_i = DW'(r_div); bus.rmode_i = 2'd1; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (r_k) @(negedge clk);
    chk("abort/busy_before", bus.busy_o, 1'b1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort/idle", {bus.busy_o, sd_clk, sd_cmd_oe, bus.done_o}, 4'b0000);
    r_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) r_done++;
    end
    chk("abort/no_done", r_done, 0);

    // start and abort together in IDLE
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    chk("start_abort/busy", {bus.busy_o, sd_cmd_oe}, 2'b00);

    // reset while receiving a long response
    bus.div_i = DW'(1); bus.idx_i = 6'd9; bus.arg_i = 32'h1234_0000; bus.rmode_i = 2'd2;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; sd_cmd_i = 1'b0;
    repeat (200) @(negedge clk);
    sd_cmd_i = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst/in_rx", {bus.busy_o, sd_cmd_oe, (bus.resp_o != 136'd0)}, 3'b101);
    #2 rstn = 1'b0;
    #1;
    chk("rst/ctl", {sd_clk, sd_cmd_o, sd_cmd_oe, bus.busy_o, bus.done_o,
                    bus.timeout_o, bus.crc_err_o}, 7'b0100000);
    chk("rst/resp", bus.resp_o, 136'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
